// File: rtl/nios2_c_cpu_oci_mem_arbiter_if.sv
// nios2_c_cpu_oci_mem_arbiter_if: Avalon-style CPU monitor-mode slave port of the OCI RAM arbiter
interface nios2_c_cpu_oci_mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;
   modport master (
      output read, write, address, writedata,
      input  waitrequest, readdata, readdatavalid
   );
   modport slave (
      input  read, write, address, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/nios2_c_cpu_oci_mem_arbiter.sv
// nios2_c_cpu_oci_mem_arbiter: round-robin JTAG/CPU arbiter and access sequencer for the OCI debug RAM
module nios2_c_cpu_oci_mem_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int RAM_LAT = 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        jtag_req,
   input  logic                        jtag_wr,
   input  logic [ADDR_W-1:0]           jtag_addr,
   input  logic [DATA_W-1:0]           jtag_wdata,
   output logic                        jtag_busy,
   output logic [DATA_W-1:0]           jtag_rdata,
   output logic                        jtag_rvalid,
   output logic                        jtag_ovf,
   input  logic                        jtag_ovf_clr,
   nios2_c_cpu_oci_mem_arbiter_if.slave cpu,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic [DATA_W-1:0]           ram_wrdata,
   output logic                        ram_wren,
   output logic                        ram_rden,
   input  logic [DATA_W-1:0]           ram_rddata
);
   localparam int CNT_W = $clog2(RAM_LAT + 1);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RWAIT} state_t;
   state_t            state_q, state_d;
   logic              pend_v_q, pend_v_d;
   logic              pend_wr_q, pend_wr_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;
   logic              last_q, last_d;
   logic              cmd_jtag_q, cmd_jtag_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] jrdata_q, jrdata_d;
   logic              jrvalid_q, jrvalid_d;
   logic [DATA_W-1:0] crdata_q, crdata_d;
   logic              crdv_q, crdv_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wrdata_q, ram_wrdata_d;
   logic              ram_wren_q, ram_wren_d;
   logic              ram_rden_q, ram_rden_d;
   logic              cpu_cmd, gnt_jtag, gnt_cpu;
   // last_q = 1 means JTAG was granted last, so a tie goes to the CPU
   always_comb begin
      cpu_cmd  = cpu.read | cpu.write;
      gnt_jtag = (state_q == S_IDLE) & pend_v_q & (~cpu_cmd | ~last_q);
      gnt_cpu  = (state_q == S_IDLE) & cpu_cmd & ~gnt_jtag;
   end
   assign cpu.waitrequest   = reset_n & cpu_cmd & ~gnt_cpu;
   assign cpu.readdata      = crdata_q;
   assign cpu.readdatavalid = crdv_q;
   assign jtag_busy         = busy_q;
   assign jtag_rdata        = jrdata_q;
   assign jtag_rvalid       = jrvalid_q;
   assign jtag_ovf          = ovf_q;
   assign ram_addr          = ram_addr_q;
   assign ram_wrdata        = ram_wrdata_q;
   assign ram_wren          = ram_wren_q;
   assign ram_rden          = ram_rden_q;
   // pending-request capture, grant, RAM access sequencing and read-data return
   always_comb begin
      state_d      = state_q;
      pend_v_d     = pend_v_q;
      pend_wr_d    = pend_wr_q;
      pend_addr_d  = pend_addr_q;
      pend_wdata_d = pend_wdata_q;
      busy_d       = busy_q;
      last_d       = last_q;
      cmd_jtag_d   = cmd_jtag_q;
      cmd_wr_d     = cmd_wr_q;
      cnt_d        = cnt_q;
      jrdata_d     = jrdata_q;
      crdata_d     = crdata_q;
      ram_addr_d   = ram_addr_q;
      ram_wrdata_d = ram_wrdata_q;
      jrvalid_d    = 1'b0;
      crdv_d       = 1'b0;
      ram_wren_d   = 1'b0;
      ram_rden_d   = 1'b0;
      ovf_d        = (ovf_q & ~jtag_ovf_clr) | (jtag_req & busy_q);
      if (jtag_req & ~busy_q) begin
         pend_v_d     = 1'b1;
         pend_wr_d    = jtag_wr;
         pend_addr_d  = jtag_addr;
         pend_wdata_d = jtag_wdata;
         busy_d       = 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (gnt_jtag | gnt_cpu) begin
               if (gnt_jtag) pend_v_d = 1'b0;
               cmd_jtag_d   = gnt_jtag;
               cmd_wr_d     = gnt_jtag ? pend_wr_q : cpu.write;
               last_d       = gnt_jtag;
               ram_addr_d   = gnt_jtag ? pend_addr_q : cpu.address;
               ram_wrdata_d = cmd_wr_d ? (gnt_jtag ? pend_wdata_q : cpu.writedata) : ram_wrdata_q;
               ram_wren_d   = cmd_wr_d;
               ram_rden_d   = ~cmd_wr_d;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cmd_wr_q) begin
               state_d = S_IDLE;
               if (cmd_jtag_q) busy_d = 1'b0;
            end else begin
               state_d = S_RWAIT;
               cnt_d   = CNT_W'(RAM_LAT);
            end
         end
         S_RWAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               if (cmd_jtag_q) begin
                  jrdata_d  = ram_rddata;
                  jrvalid_d = 1'b1;
                  busy_d    = 1'b0;
               end else begin
                  crdata_d = ram_rddata;
                  crdv_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   // state and output registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         pend_v_q     <= 1'b0;
         pend_wr_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_wdata_q <= '0;
         busy_q       <= 1'b0;
         ovf_q        <= 1'b0;
         last_q       <= 1'b0;
         cmd_jtag_q   <= 1'b0;
         cmd_wr_q     <= 1'b0;
         cnt_q        <= '0;
         jrdata_q     <= '0;
         jrvalid_q    <= 1'b0;
         crdata_q     <= '0;
         crdv_q       <= 1'b0;
         ram_addr_q   <= '0;
         ram_wrdata_q <= '0;
         ram_wren_q   <= 1'b0;
         ram_rden_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_v_q     <= pend_v_d;
         pend_wr_q    <= pend_wr_d;
         pend_addr_q  <= pend_addr_d;
         pend_wdata_q <= pend_wdata_d;
         busy_q       <= busy_d;
         ovf_q        <= ovf_d;
         last_q       <= last_d;
         cmd_jtag_q   <= cmd_jtag_d;
         cmd_wr_q     <= cmd_wr_d;
         cnt_q        <= cnt_d;
         jrdata_q     <= jrdata_d;
         jrvalid_q    <= jrvalid_d;
         crdata_q     <= crdata_d;
         crdv_q       <= crdv_d;
         ram_addr_q   <= ram_addr_d;
         ram_wrdata_q <= ram_wrdata_d;
         ram_wren_q   <= ram_wren_d;
         ram_rden_q   <= ram_rden_d;
      end
   end
endmodule

// File: tb/tb_nios2_c_cpu_oci_mem_arbiter.sv
// tb_nios2_c_cpu_oci_mem_arbiter: scoreboard bench for the OCI RAM arbiter at RAM_LAT 1 and 3
module tb_nios2_c_cpu_oci_mem_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int n_cmp = 0;
   int n_err = 0;
   logic        jtag_req = 1'b0, jtag_wr = 1'b0, jtag_ovf_clr = 1'b0;
   logic [7:0]  jtag_addr = '0;
   logic [31:0] jtag_wdata = '0;
   logic        jtag_busy, jtag_rvalid, jtag_ovf;
   logic [31:0] jtag_rdata;
   logic [7:0]  ram_addr_a;
   logic [31:0] ram_wrdata_a, rd_a;
   logic        ram_wren_a, ram_rden_a;
   logic        b_jreq = 1'b0, b_jwr = 1'b0, b_jclr = 1'b0;
   logic [7:0]  b_jaddr = '0;
   logic [31:0] b_jwdata = '0;
   logic        b_jbusy, b_jrvalid, b_jovf;
   logic [31:0] b_jrdata;
   logic [7:0]  ram_addr_b;
   logic [31:0] ram_wrdata_b, rd_b1, rd_b2, rd_b3;
   logic        ram_wren_b, ram_rden_b;
   nios2_c_cpu_oci_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) cpu_a ();
   nios2_c_cpu_oci_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) cpu_b ();
   nios2_c_cpu_oci_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RAM_LAT(1)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
      .jtag_busy(jtag_busy), .jtag_rdata(jtag_rdata), .jtag_rvalid(jtag_rvalid),
      .jtag_ovf(jtag_ovf), .jtag_ovf_clr(jtag_ovf_clr), .cpu(cpu_a.slave),
      .ram_addr(ram_addr_a), .ram_wrdata(ram_wrdata_a), .ram_wren(ram_wren_a),
      .ram_rden(ram_rden_a), .ram_rddata(rd_a)
   );
   nios2_c_cpu_oci_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RAM_LAT(3)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .jtag_req(b_jreq), .jtag_wr(b_jwr), .jtag_addr(b_jaddr), .jtag_wdata(b_jwdata),
      .jtag_busy(b_jbusy), .jtag_rdata(b_jrdata), .jtag_rvalid(b_jrvalid),
      .jtag_ovf(b_jovf), .jtag_ovf_clr(b_jclr), .cpu(cpu_b.slave),
      .ram_addr(ram_addr_b), .ram_wrdata(ram_wrdata_b), .ram_wren(ram_wren_b),
      .ram_rden(ram_rden_b), .ram_rddata(rd_b3)
   );
   wire [110:0] outs_a = {jtag_busy, jtag_ovf, jtag_rdata, jtag_rvalid, cpu_a.readdata,
                          cpu_a.readdatavalid, cpu_a.waitrequest, ram_addr_a, ram_wrdata_a,
                          ram_wren_a, ram_rden_a};
   // RAM models: read data is valid exactly RAM_LAT cycles after rden, zero otherwise
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   always @(posedge clk) begin
      if (ram_wren_a) mem_a[ram_addr_a] <= ram_wrdata_a;
      rd_a <= ram_rden_a ? mem_a[ram_addr_a] : 32'h0;
      if (ram_wren_b) mem_b[ram_addr_b] <= ram_wrdata_b;
      rd_b1 <= ram_rden_b ? mem_b[ram_addr_b] : 32'h0;
      rd_b2 <= rd_b1;
      rd_b3 <= rd_b2;
   end
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   logic [31:0] sh [256];
   logic [31:0] exp_c [$];
   logic [31:0] exp_j [$];
   logic [8:0]  acc_q [$];
   int acc_cyc = -1, crdv_cyc = -1, crdv_n = 0;
   // scoreboard: push expectations on accepted commands, pop on returned read data
   always @(negedge clk) begin
      if (reset_n) begin
         if ((cpu_a.read | cpu_a.write) && !cpu_a.waitrequest) begin
            if (cpu_a.write) sh[cpu_a.address] = cpu_a.writedata;
            else exp_c.push_back(sh[cpu_a.address]);
         end
         if (jtag_req && !jtag_busy) begin
            if (jtag_wr) sh[jtag_addr] = jtag_wdata;
            else exp_j.push_back(sh[jtag_addr]);
         end
         if (ram_wren_a | ram_rden_a) begin
            acc_q.push_back({ram_wren_a, ram_addr_a});
            acc_cyc = cyc;
         end
         if (cpu_a.readdatavalid) begin
            crdv_cyc = cyc;
            crdv_n++;
            if (exp_c.size() == 0) chk("cpu_rdv_unexpected", 128'(cpu_a.readdatavalid), 0);
            else chk("cpu_rdata", cpu_a.readdata, exp_c.pop_front());
         end
         if (jtag_rvalid) begin
            if (exp_j.size() == 0) chk("jtag_rvalid_unexpected", 128'(jtag_rvalid), 0);
            else chk("jtag_rdata", jtag_rdata, exp_j.pop_front());
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [31:0] d, output int t);
      cpu_a.write = wr;
      cpu_a.read = !wr;
      cpu_a.address = a;
      cpu_a.writedata = d;
      #1;
      t = -1;
      for (int k = 0; k < 50 && cpu_a.waitrequest; k++) begin
         @(posedge clk);
         #2;
      end
      if (cpu_a.waitrequest) chk("cpu_accept_timeout", 128'(cpu_a.waitrequest), 0);
      else t = cyc;
      tick();
      cpu_a.read = 1'b0;
      cpu_a.write = 1'b0;
   endtask
   task automatic jtag_op(input logic wr, input logic [7:0] a, input logic [31:0] d, output int t);
      jtag_req = 1'b1;
      jtag_wr = wr;
      jtag_addr = a;
      jtag_wdata = d;
      t = cyc;
      tick();
      jtag_req = 1'b0;
   endtask
   task automatic drain();
      int k = 0;
      while (k < 40 && (jtag_busy || exp_c.size() != 0 || exp_j.size() != 0)) begin
         tick();
         k++;
      end
      chk("drain_timeout", 128'(k < 40), 1);
      tick();
      tick();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
   initial begin
      int t, r, m, n, first_cpu, hi_n;
      logic jprev;
      logic [8:0] e;
      cpu_a.read = 0; cpu_a.write = 0; cpu_a.address = 0; cpu_a.writedata = 0;
      cpu_b.read = 0; cpu_b.write = 0; cpu_b.address = 0; cpu_b.writedata = 0;
      repeat (3) tick();
      chk("reset_outputs", outs_a, 0);
      reset_n = 1'b1;
      tick();
      // CPU write then read back
      cpu_op(1'b1, 8'h10, 32'hDEADBEEF, t);
      tick(); tick();
      chk("wr_ram_cycle", acc_cyc, t + 1);
      chk("wr_ram_cmd", acc_q[$], {1'b1, 8'h10});
      crdv_cyc = -1;
      cpu_op(1'b0, 8'h10, 32'h0, t);
      drain();
      chk("rd_valid_cycle", crdv_cyc, t + 3);
      chk("rd_ram_cmd", acc_q[$], {1'b0, 8'h10});
      // JTAG read of a CPU-written word
      cpu_op(1'b1, 8'h05, 32'h12345678, t);
      tick(); tick();
      jtag_op(1'b0, 8'h05, 32'h0, t);
      for (int k = 1; k < 4; k++) begin
         chk("jtag_busy_high", jtag_busy, 1);
         tick();
      end
      chk("jtag_busy_fall", jtag_busy, 0);
      chk("jtag_rvalid_cycle", jtag_rvalid, 1);
      tick();
      chk("jtag_rvalid_pulse", jtag_rvalid, 0);
      drain();
      chk("jtag_rdata_hold", jtag_rdata, 32'h12345678);
      // JTAG write then CPU read
      jtag_op(1'b1, 8'h40, 32'hFEEDC0DE, t);
      chk("jwr_busy_t1", jtag_busy, 1);
      tick();
      chk("jwr_busy_t2", jtag_busy, 1);
      tick();
      chk("jwr_busy_t3", jtag_busy, 0);
      cpu_op(1'b0, 8'h40, 32'h0, t);
      drain();
      // reset in the middle of a CPU read
      cpu_op(1'b0, 8'h10, 32'h0, t);
      reset_n = 1'b0;
      exp_c.delete();
      exp_j.delete();
      #1;
      chk("mid_reset_outputs", outs_a, 0);
      n = crdv_n;
      tick(); tick();
      reset_n = 1'b1;
      r = cyc;
      cpu_op(1'b0, 8'h10, 32'h0, t);
      chk("post_reset_idle", t, r);
      drain();
      chk("post_reset_one_valid", crdv_n, n + 1);
      // contention: JTAG and CPU always requesting
      cpu_op(1'b1, 8'h20, 32'hA5A50020, t);
      cpu_op(1'b1, 8'h30, 32'h5A5A0030, t);
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      m = acc_q.size();
      t = cyc;
      first_cpu = -1;
      hi_n = 0;
      jprev = 1'b0;
      for (int k = 0; k < 40 && acc_q.size() < m + 4; k++) begin
         jtag_req = !jtag_busy && !jprev;
         jtag_wr = 1'b0;
         jtag_addr = 8'h20;
         jprev = jtag_req;
         cpu_a.read = (k >= 1);
         cpu_a.address = 8'h30;
         #1;
         if (cpu_a.read && first_cpu < 0) begin
            if (cpu_a.waitrequest) hi_n++;
            else first_cpu = cyc;
         end
         tick();
      end
      jtag_req = 1'b0;
      cpu_a.read = 1'b0;
      chk("cont_first_cpu_grant", first_cpu, t + 4);
      chk("cont_waitrequest_high", hi_n, 3);
      chk("cont_access_count", 128'(acc_q.size() >= m + 4), 1);
      for (int i = 0; i < 4; i++) begin
         e = acc_q[m + i];
         chk("cont_order", e[7:0], (i % 2 == 0) ? 8'h20 : 8'h30);
      end
      drain();
      // overrun: second request while busy is dropped and flagged
      m = acc_q.size();
      jtag_op(1'b0, 8'h20, 32'h0, t);
      jtag_req = 1'b1;
      jtag_addr = 8'h30;
      tick();
      jtag_req = 1'b0;
      chk("ovf_set", jtag_ovf, 1);
      drain();
      chk("ovf_single_access", acc_q.size(), m + 1);
      e = acc_q[$];
      chk("ovf_orig_addr", e[7:0], 8'h20);
      chk("ovf_sticky", jtag_ovf, 1);
      jtag_ovf_clr = 1'b1;
      tick();
      jtag_ovf_clr = 1'b0;
      chk("ovf_clear", jtag_ovf, 0);
      jtag_op(1'b0, 8'h30, 32'h0, t);
      jtag_req = 1'b1;
      jtag_ovf_clr = 1'b1;
      tick();
      jtag_req = 1'b0;
      jtag_ovf_clr = 1'b0;
      chk("ovf_set_wins", jtag_ovf, 1);
      drain();
      // RAM_LAT = 3 instance
      cpu_b.write = 1'b1;
      cpu_b.address = 8'h07;
      cpu_b.writedata = 32'hCAFEF00D;
      #1;
      chk("lat3_wr_accept", cpu_b.waitrequest, 0);
      tick();
      cpu_b.write = 1'b0;
      tick(); tick();
      cpu_b.read = 1'b1;
      #1;
      chk("lat3_rd_accept", cpu_b.waitrequest, 0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         if (k < 5) begin
            chk("lat3_waitrequest", cpu_b.waitrequest, 1);
            chk("lat3_early_valid", cpu_b.readdatavalid, 0);
         end else begin
            chk("lat3_valid", cpu_b.readdatavalid, 1);
            chk("lat3_rdata", cpu_b.readdata, 32'hCAFEF00D);
            cpu_b.read = 1'b0;
         end
         tick();
      end
      repeat (6) tick();
      chk("cpu_queue_empty", exp_c.size(), 0);
      chk("jtag_queue_empty", exp_j.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
